rx_drain_arb: RTL and testbench

RX_DRAIN_ARB -- requirements
Module: rx_drain_arb

---
 rtl/uart_pkg.sv | 18 +
 rtl/rx_idle_timer.sv | 47 ++++
 rtl/rx_drain_arb.sv | 135 +++++++++++++
 tb/tb_rx_drain_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and constants for the RX drain arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int NUM_CH    = 2;
  localparam int BURST_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/rx_idle_timer.sv
`default_nettype none
// ============================================================================
// Module  : rx_idle_timer
// Brief   : Per-channel idle counter and registered level interrupt.
// Revision: 1.0 - initial release
// ============================================================================
module rx_idle_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          empty,
  input  logic [CW-1:0] count,
  input  logic [CW-1:0] thresh,
  input  logic [7:0]    tmo_cfg,
  output logic          irq
);

  logic [CW-1:0] r_prev_count;
  logic [7:0]    r_idle;
  logic          r_irq;
  logic          w_thresh_hit;
  logic          w_tmo_hit;

  assign w_thresh_hit = (thresh != '0) && (count >= thresh);
  assign w_tmo_hit    = (tmo_cfg != 8'd0) && !empty && (r_idle >= tmo_cfg);
  assign irq          = r_irq;

  // Any occupancy movement (push or pop) counts as activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_count <= '0;
      r_idle       <= 8'd0;
      r_irq        <= 1'b0;
    end else begin
      r_prev_count <= count;
      if (empty || (count != r_prev_count)) begin
        r_idle <= 8'd0;
      end else if (r_idle != 8'hFF) begin
        r_idle <= r_idle + 8'd1;
      end
      r_irq <= w_thresh_hit || w_tmo_hit;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_drain_arb.sv
`default_nettype none
// ============================================================================
// Module  : rx_drain_arb
// Brief   : Two-channel RX FIFO drain with burst round-robin and interrupts.
// Revision: 1.0 - initial release
// ============================================================================
module rx_drain_arb
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1,
  parameter int BURST = BURST_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    rx_empty,
  input  logic [CW-1:0] rx_count0,
  input  logic [CW-1:0] rx_count1,
  input  logic [7:0]    rx_data0,
  input  logic [7:0]    rx_data1,
  output logic [1:0]    rx_read,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_chan,
  input  logic          out_ready,
  input  logic [CW-1:0] thresh0,
  input  logic [CW-1:0] thresh1,
  input  logic [7:0]    tmo_cfg,
  output logic [1:0]    irq
);

  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] c_burst_max = BW'(BURST);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_last;
  logic [BW-1:0] r_burst;
  logic [7:0]    r_data;
  logic          r_chan;
  logic          w_any;
  logic          w_keep;
  logic          w_grant;
  logic          w_pop;

  assign w_any = (rx_empty != 2'b11);
  // A zero burst count means no run is in progress, so the pointer's peer wins.
  assign w_keep = (r_burst != '0) && (r_burst < c_burst_max) && !rx_empty[r_last];

  always_comb begin
    w_grant = r_last;
    if (!w_keep && !rx_empty[~r_last]) begin
      w_grant = ~r_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // rst_n gates the pop so no FIFO is drained while reset is held.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    rx_read      = 2'b00;
    case (r_state)
      IDLE: begin
        w_pop = rst_n && w_any;
      end
      HOLD: begin
        w_pop = rst_n && out_ready && w_any;
        if (out_ready && !w_any) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_pop) begin
      w_state_next = HOLD;
      rx_read      = w_grant ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_burst <= '0;
      r_data  <= 8'h00;
      r_chan  <= 1'b0;
    end else if (w_pop) begin
      r_data <= w_grant ? rx_data1 : rx_data0;
      r_chan <= w_grant;
      r_last <= w_grant;
      if ((w_grant == r_last) && (r_burst != '0)) begin
        if (r_burst != c_burst_max) begin
          r_burst <= r_burst + 1'b1;
        end
      end else begin
        r_burst <= BW'(1);
      end
    end
  end

  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign out_chan  = r_chan;

  logic [CW-1:0] w_count  [NUM_CH];
  logic [CW-1:0] w_thresh [NUM_CH];

  assign w_count[0]  = rx_count0;
  assign w_count[1]  = rx_count1;
  assign w_thresh[0] = thresh0;
  assign w_thresh[1] = thresh1;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    rx_idle_timer #(
      .CW(CW)
    ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .empty   (rx_empty[gi]),
      .count   (w_count[gi]),
      .thresh  (w_thresh[gi]),
      .tmo_cfg (tmo_cfg),
      .irq     (irq[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_drain_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_rx_drain_arb
// Brief   : Self-checking bench with FIFO queues and a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rx_drain_arb;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    rx_empty;
  logic [CW-1:0] rx_count0, rx_count1;
  logic [7:0]    rx_data0, rx_data1;
  logic [1:0]    rx_read;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_chan;
  logic          out_ready;
  logic [CW-1:0] thresh0, thresh1;
  logic [7:0]    tmo_cfg;
  logic [1:0]    irq;

  always #5 clk = ~clk;

  rx_drain_arb #(.DEPTH(DEPTH), .CW(CW), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_empty  (rx_empty),
    .rx_count0 (rx_count0),
    .rx_count1 (rx_count1),
    .rx_data0  (rx_data0),
    .rx_data1  (rx_data1),
    .rx_read   (rx_read),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready),
    .thresh0   (thresh0),
    .thresh1   (thresh1),
    .tmo_cfg   (tmo_cfg),
    .irq       (irq)
  );

  // FIFO contents and the consumer-visible model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         glog[$];
  int         checks   = 0;
  int         failures = 0;

  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_cur;
  int         m_run;
  int         m_idle[2];
  int         m_prev[2];
  bit         m_irq[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_chan  = 0;
    m_cur   = 1;
    m_run   = 0;
    for (int i = 0; i < 2; i++) begin
      m_idle[i] = 0;
      m_prev[i] = 0;
      m_irq[i]  = 1'b0;
    end
  endtask

  task automatic drive();
    rx_count0   = CW'(q0.size());
    rx_count1   = CW'(q1.size());
    rx_empty[0] = (q0.size() == 0);
    rx_empty[1] = (q1.size() == 0);
    rx_data0    = (q0.size() != 0) ? q0[0] : 8'h00;
    rx_data1    = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    if (ch == 0 && q0.size() < DEPTH) q0.push_back(b);
    if (ch == 1 && q1.size() < DEPTH) q1.push_back(b);
  endtask

  // One clock cycle: entered just after a rising edge, leaves just after the next.
  task automatic step();
    int   cnt[2];
    int   th[2];
    int   nidle[2];
    bit   nirq[2];
    int   g;
    bit   pop;
    logic [1:0] exp_read;
    drive();
    #2;
    cnt[0] = q0.size();
    cnt[1] = q1.size();
    th[0]  = int'(thresh0);
    th[1]  = int'(thresh1);
    pop    = (!m_valid || out_ready) && (cnt[0] + cnt[1] > 0);
    if (cnt[0] == 0)                    g = 1;
    else if (cnt[1] == 0)               g = 0;
    else if (m_run > 0 && m_run < BURST) g = m_cur;
    else                                g = 1 - m_cur;
    exp_read = pop ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;

    check("rx_read", rx_read, exp_read);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_chan", out_chan, m_chan);
    end
    check("irq", irq, {m_irq[1], m_irq[0]});
    if (rx_read != 2'b00) glog.push_back(rx_read[1] ? 1 : 0);

    for (int i = 0; i < 2; i++) begin
      nirq[i] = (th[i] != 0 && cnt[i] >= th[i]) ||
                (tmo_cfg != 8'd0 && cnt[i] != 0 && m_idle[i] >= int'(tmo_cfg));
      if (cnt[i] == 0 || cnt[i] != m_prev[i]) nidle[i] = 0;
      else nidle[i] = (m_idle[i] < 255) ? m_idle[i] + 1 : 255;
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_irq[i]  = nirq[i];
      m_idle[i] = nidle[i];
      m_prev[i] = cnt[i];
    end
    if (pop) begin
      if (g == 1) m_data = q1.pop_front();
      else        m_data = q0.pop_front();
      m_chan  = g;
      m_valid = 1'b1;
      if (g == m_cur && m_run > 0) m_run = (m_run < BURST) ? m_run + 1 : BURST;
      else                         m_run = 1;
      m_cur = g;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Synchronised reset entry: called just after a rising edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    drive();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_rx_read", rx_read, 2'b00);
    check("rst_irq", irq, 2'b00);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ready_pct;
    int push_pct;
    logic [31:0] exp_order;

    rst_n     = 1'b0;
    out_ready = 1'b0;
    thresh0   = '0;
    thresh1   = '0;
    tmo_cfg   = 8'd0;
    model_reset();
    drive();
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_chan", out_chan, 1'b0);
    check("rst_rx_read", rx_read, 2'b00);
    check("rst_irq", irq, 2'b00);

    // Three bytes on channel 0 only, streaming consumer
    push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    drive();
    #1;
    check("rst_hold_no_pop", rx_read, 2'b00);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    glog.delete();
    for (int k = 0; k < 5; k++) step();
    check("ch0_pop_count", glog.size(), 3);

    // Both channels full of 8: burst-limited alternation
    apply_reset();
    q0.delete(); q1.delete();
    for (int k = 0; k < 8; k++) begin
      push(0, 8'(8'h10 + k));
      push(1, 8'(8'h80 + k));
    end
    rst_n = 1'b1;
    glog.delete();
    for (int k = 0; k < 17; k++) step();
    exp_order = 32'h0000_F0F0;
    check("grant_len", glog.size(), 16);
    for (int k = 0; k < 16 && k < glog.size(); k++) begin
      check("grant_order", glog[k], exp_order[k]);
    end

    // Stalled hold, idle timeout on channel 0, threshold on channel 1
    apply_reset();
    q0.delete(); q1.delete();
    out_ready = 1'b0;
    tmo_cfg   = 8'd10;
    thresh0   = '0;
    thresh1   = CW'(4);
    push(0, 8'h55); push(0, 8'h66); push(0, 8'h77);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) step();
    check("hold_data", out_data, 8'h55);
    check("irq0_timeout", irq[0], 1'b1);
    for (int k = 0; k < 4; k++) begin
      push(1, 8'(8'hC0 + k));
      step();
    end
    step();
    check("irq1_thresh", irq[1], 1'b1);

    // Asynchronous reset in the middle of a held byte
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_irq", irq, 2'b00);
    check("mid_rst_read", rx_read, 2'b00);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    glog.delete();
    step();
    check("post_rst_first", (glog.size() > 0) ? glog[0] : 9, 0);

    // Randomised traffic with shifting consumer and configuration
    ready_pct = 80;
    push_pct  = 50;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc % 90 == 0) begin
        case ($urandom_range(0, 3))
          0:       ready_pct = 0;
          1:       ready_pct = 30;
          2:       ready_pct = 80;
          default: ready_pct = 100;
        endcase
        case ($urandom_range(0, 3))
          0:       push_pct = 0;
          1:       push_pct = 20;
          2:       push_pct = 60;
          default: push_pct = 95;
        endcase
        thresh0 = CW'($urandom_range(0, DEPTH));
        thresh1 = CW'($urandom_range(0, DEPTH));
        tmo_cfg = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(2, 20));
      end
      if (cyc == 450) apply_reset();
      rst_n     = 1'b1;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if ($urandom_range(0, 99) < push_pct) push(0, 8'($urandom));
      if ($urandom_range(0, 99) < push_pct) push(1, 8'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
